// File: rtl/dmem_pkg.sv
// Shared types for the Y86-64 memory stage: icode constants, status codes,
// FSM states and the decoded memory request.
package dmem_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {S_AOK = 2'b00, S_HLT = 2'b01, S_ADR = 2'b10, S_INS = 2'b11} stat_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mreq_t;

    function automatic mreq_t decode(input logic [3:0] icode, input logic [63:0] valE,
                                     input logic [63:0] valA, input logic [63:0] valP);
        mreq_t m;
        m = '0;
        case (icode)
            I_MRMOVQ:         begin m.rd = 1'b1; m.addr = valE; end
            I_RET, I_POPQ:    begin m.rd = 1'b1; m.addr = valA; end
            I_RMMOVQ, I_PUSHQ: begin m.wr = 1'b1; m.addr = valE; m.wdata = valA; end
            I_CALL:           begin m.wr = 1'b1; m.addr = valE; m.wdata = valP; end
            default: ;
        endcase
        return m;
    endfunction
endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between execute, the memory stage and write-back.
interface dmem_if #(parameter int DATA_W = 64);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        icode;
    logic [63:0]       valE;
    logic [63:0]       valA;
    logic [63:0]       valP;
    logic              instr_valid;
    logic              imem_error;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] valM;
    logic [1:0]        stat;
    logic              dmem_err;

    modport master (output in_valid, icode, valE, valA, valP, instr_valid, imem_error, out_ready,
                    input  in_ready, out_valid, valM, stat, dmem_err);
    modport slave  (input  in_valid, icode, valE, valA, valP, instr_valid, imem_error, out_ready,
                    output in_ready, out_valid, valM, stat, dmem_err);
endinterface

// File: rtl/byte_ram.sv
// Byte-addressed little-endian RAM: combinational word read, synchronous
// word write with per-byte enables. Contents are never reset.
module byte_ram #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);
    localparam int BYTES = DATA_W / 8;

    logic [7:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++)
            if (i_we && i_be[i]) r_mem[i_waddr + ADDR_W'(i)] <= i_wdata[8*i +: 8];
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < BYTES; i++)
            o_rdata[8*i +: 8] = r_mem[i_raddr + ADDR_W'(i)];
    end
endmodule

// File: rtl/dmem_stage.sv
// Y86-64 memory stage: decode, bounds check, latency-programmable access FSM
// and held result registers behind a valid/ready handshake.
module dmem_stage
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int BYTES = DATA_W / 8;

    state_e            r_state;
    logic [3:0]        r_cnt;
    logic              r_rd, r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_valM;
    stat_e             r_stat;
    logic              r_err;

    mreq_t             w_req;
    logic              w_fetch_ok, w_mem, w_oob, w_err, w_go;
    logic [ADDR_W:0]   w_end;
    stat_e             w_stat;
    logic              w_idle, w_in_ready, w_accept, w_last, w_commit, w_we;
    logic              w_a_rd, w_a_wr;
    logic [ADDR_W-1:0] w_a_addr;
    logic [DATA_W-1:0] w_a_wdata, w_rdata;

    assign w_req      = decode(bus.icode, bus.valE, bus.valA, bus.valP);
    assign w_fetch_ok = bus.instr_valid & ~bus.imem_error;
    assign w_mem      = (w_req.rd | w_req.wr) & w_fetch_ok;
    // End address at ADDR_W+1 bits so an access straddling the top never wraps.
    assign w_end      = {1'b0, w_req.addr[ADDR_W-1:0]} + (ADDR_W+1)'(BYTES - 1);
    assign w_oob      = (|w_req.addr[63:ADDR_W]) | w_end[ADDR_W];
    assign w_err      = w_mem & w_oob;
    assign w_go       = w_mem & ~w_oob;

    always_comb begin
        w_stat = S_AOK;
        if (bus.imem_error)        w_stat = S_ADR;
        else if (!bus.instr_valid) w_stat = S_INS;
        else if (w_err)            w_stat = S_ADR;
        else if (bus.icode == I_HALT) w_stat = S_HLT;
    end

    assign w_idle     = (r_state == ST_IDLE);
    assign w_in_ready = rst & w_idle;
    assign w_accept   = bus.in_valid & w_in_ready;

    // The accept cycle is the first access cycle, so MEM_LAT==1 commits on
    // the accept edge straight from the live inputs and skips ACCESS.
    assign w_last    = (r_state == ST_ACCESS) && (r_cnt == 4'(MEM_LAT - 1));
    assign w_commit  = w_idle ? (w_accept & w_go & (MEM_LAT == 1)) : w_last;
    assign w_a_rd    = w_idle ? w_req.rd : r_rd;
    assign w_a_wr    = w_idle ? w_req.wr : r_wr;
    assign w_a_addr  = w_idle ? w_req.addr[ADDR_W-1:0] : r_addr;
    assign w_a_wdata = w_idle ? DATA_W'(w_req.wdata) : r_wdata;
    assign w_we      = w_commit & w_a_wr & rst;

    byte_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    ({BYTES{1'b1}}),
        .i_waddr (w_a_addr),
        .i_wdata (w_a_wdata),
        .i_raddr (w_a_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_valM  <= '0;
            r_stat  <= S_AOK;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_stat  <= w_stat;
                    r_err   <= w_err;
                    r_valM  <= '0;
                    r_rd    <= w_req.rd;
                    r_wr    <= w_req.wr;
                    r_addr  <= w_req.addr[ADDR_W-1:0];
                    r_wdata <= DATA_W'(w_req.wdata);
                    if (w_go && MEM_LAT > 1) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= 4'd1;
                    end else begin
                        r_state <= ST_DONE;
                        if (w_go && w_req.rd) r_valM <= w_rdata;
                    end
                end
                ST_ACCESS: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                        if (r_rd) r_valM <= w_rdata;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_DONE: if (bus.out_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.valM      = r_valM;
    assign bus.stat      = r_stat;
    assign bus.dmem_err  = r_err;
endmodule

// File: tb/tb_dmem_stage.sv
// Scoreboard bench for dmem_stage: a byte-array reference model predicts each
// result at issue time; a negedge monitor checks results, latency and stalls.
module tb_dmem_stage;
    localparam int LAT   = 2;
    localparam int MEMSZ = 65536;

    typedef struct {
        logic [63:0] valM;
        logic [1:0]  stat;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_if #(.DATA_W(64)) bus ();
    dmem_stage #(.ADDR_W(16), .DATA_W(64), .MEM_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   n_chk = 0, n_pass = 0;
    int   cyc = 0;
    int   bp_mode = 0, hold = 0;
    logic [7:0] mm [int];
    exp_t exp_q[$];
    int   acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: read/write/none, used address, bounds by plain arithmetic.
    task automatic model(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p, input bit iv, input bit ie, input bit commit,
                         output exp_t x);
        bit rd, wr, acc, err;
        logic [63:0] addr, data;
        rd   = (ic == 4'h5 || ic == 4'h9 || ic == 4'hB);
        wr   = (ic == 4'h4 || ic == 4'h8 || ic == 4'hA);
        addr = (ic == 4'h9 || ic == 4'hB) ? a : e;
        data = (ic == 4'h8) ? p : a;
        acc  = iv && !ie && (rd || wr);
        err  = acc && (addr > 64'(MEMSZ - 8));
        x.stat = ie ? 2'd2 : (!iv ? 2'd3 : (err ? 2'd2 : (ic == 4'h0 ? 2'd1 : 2'd0)));
        x.err  = err;
        x.valM = '0;
        x.lat  = (acc && !err) ? LAT : 1;
        if (acc && !err) begin
            if (rd) for (int i = 0; i < 8; i++) x.valM[8*i +: 8] = mm[int'(addr[31:0]) + i];
            if (wr && commit) for (int i = 0; i < 8; i++) mm[int'(addr[31:0]) + i] = data[8*i +: 8];
        end
    endtask

    task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p, input bit iv, input bit ie, input bit expect_out);
        exp_t x;
        int t;
        model(ic, e, a, p, iv, ie, expect_out, x);
        if (expect_out) exp_q.push_back(x);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.icode = ic; bus.valE = e; bus.valA = a; bus.valP = p;
        bus.instr_valid = iv; bus.imem_error = ie;
        t = 0;
        while (!bus.in_ready && t < 200) begin @(negedge clk); t++; end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'(t), 64'd0);
            bus.in_valid = 1'b0;
            return;
        end
        if (expect_out) acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.icode = 4'($urandom); bus.valE = {$urandom, $urandom};
        bus.valA = {$urandom, $urandom}; bus.valP = {$urandom, $urandom};
        bus.instr_valid = 1'($urandom); bus.imem_error = 1'($urandom);
    endtask

    // Downstream ready: always, random, or a 3-cycle hold per result.
    always @(posedge clk) begin
        #1;
        if (bp_mode == 0) bus.out_ready = 1'b1;
        else if (bp_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
        else if (bus.out_valid) begin
            bus.out_ready = (hold >= 3);
            hold++;
        end else begin
            bus.out_ready = 1'b0;
            hold = 0;
        end
    end

    exp_t cur;
    bit   held = 0, prev_hs = 0;
    always @(negedge clk) begin
        if (!rst) begin
            held = 0; prev_hs = 0;
        end else begin
            if (prev_hs) chk("back_to_idle", {bus.out_valid, bus.in_ready}, 2'b01);
            if (bus.out_valid) begin
                if (!held) begin
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        chk("unexpected_out", 64'(exp_q.size()), 64'd1);
                        cur.valM = bus.valM; cur.stat = bus.stat; cur.err = bus.dmem_err; cur.lat = 0;
                    end else begin
                        int acc;
                        cur = exp_q.pop_front();
                        acc = acc_q.pop_front();
                        chk("valM", bus.valM, cur.valM);
                        chk("stat", 64'(bus.stat), 64'(cur.stat));
                        chk("dmem_err", 64'(bus.dmem_err), 64'(cur.err));
                        chk("latency", 64'(cyc - acc + 1), 64'(cur.lat));
                    end
                end else begin
                    chk("stall_hold", {bus.in_ready, bus.dmem_err, bus.stat, bus.valM},
                        {1'b0, cur.err, cur.stat, cur.valM});
                end
            end
            held    = bus.out_valid && !bus.out_ready;
            prev_hs = bus.out_valid && bus.out_ready;
        end
    end

    function automatic logic [63:0] rnd_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return 64'($urandom_range(0, 264));
            6, 7:             return 64'($urandom_range(65504, 65528));
            8:                return 64'($urandom_range(65529, 65560));
            default:          return {$urandom, $urandom} | (64'h1 << $urandom_range(16, 63));
        endcase
    endfunction

    initial begin
        logic [3:0]  ic;
        logic [63:0] ad, dv;
        int t;
        bus.in_valid = 1'b0; bus.icode = '0; bus.valE = '0; bus.valA = '0; bus.valP = '0;
        bus.instr_valid = 1'b1; bus.imem_error = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_valM", bus.valM, 64'd0);
        chk("rst_stat", 64'(bus.stat), 64'd0);
        chk("rst_dmem_err", 64'(bus.dmem_err), 64'd0);
        rst = 1'b1;

        // Give every byte that later reads can touch a known value.
        for (int a = 0; a <= 272; a += 8) issue(4'h4, 64'(a), {$urandom, $urandom}, 64'd0, 1, 0, 1);
        for (int a = 65504; a <= 65528; a += 8) issue(4'hA, 64'(a), {$urandom, $urandom}, 64'd0, 1, 0, 1);

        issue(4'h4, 64'd58, 64'd12, 64'd0, 1, 0, 1);
        issue(4'h5, 64'd58, 64'd0, 64'd0, 1, 0, 1);
        issue(4'h4, 64'd65536, 64'hAAAA, 64'd0, 1, 0, 1);
        issue(4'h4, 64'd65529, 64'hBBBB, 64'd0, 1, 0, 1);
        issue(4'h5, 64'd65528, 64'd0, 64'd0, 1, 0, 1);
        issue(4'h4, 64'd65528, 64'h0123_4567_89AB_CDEF, 64'd0, 1, 0, 1);
        issue(4'h5, 64'd65528, 64'd0, 64'd0, 1, 0, 1);
        issue(4'h8, 64'd100, 64'd0, 64'd11, 1, 0, 1);
        issue(4'h9, 64'd0, 64'd100, 64'd0, 1, 0, 1);
        issue(4'h5, 64'd100, 64'd0, 64'd0, 1, 0, 1);
        issue(4'h5, 64'd101, 64'd0, 64'd0, 1, 0, 1);
        issue(4'h4, 64'd120, 64'd77, 64'd0, 0, 0, 1);
        issue(4'h4, 64'd120, 64'd78, 64'd0, 0, 1, 1);
        issue(4'h5, 64'd120, 64'd0, 64'd0, 1, 0, 1);
        issue(4'h0, 64'd58, 64'd0, 64'd0, 1, 0, 1);

        bp_mode = 2;
        issue(4'h5, 64'd58, 64'd0, 64'd0, 1, 0, 1);
        issue(4'h1, 64'd0, 64'd0, 64'd0, 1, 0, 1);
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        bp_mode = 0;

        // Reset lands on the commit edge of a pending write.
        issue(4'h4, 64'd200, 64'd99, 64'd0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        issue(4'h5, 64'd200, 64'd0, 64'd0, 1, 0, 1);

        bp_mode = 1;
        for (int n = 0; n < 200; n++) begin
            ic = 4'($urandom);
            ad = rnd_addr();
            dv = {$urandom, $urandom};
            if (ic == 4'h9 || ic == 4'hB) issue(ic, {$urandom, $urandom}, ad, dv, ($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0), 1);
            else issue(ic, ad, dv, {$urandom, $urandom}, ($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0), 1);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_stage.md
# dmem_stage

Parametrised Y86-64 memory stage with a valid/ready handshake and a programmable access latency. It sits between execute and write-back. Per instruction it:
- decodes icode into a read, a write or no memory access;
- forms the address and write data from valE/valA/valP;
- checks the access against the memory bounds;
- returns valM and the 2-bit stat, held until write-back accepts them.

## Interface
- ADDR_W, 16: byte-address width; memory holds 2^ADDR_W bytes.
- DATA_W, 64: word width, multiple of 8; BYTES = DATA_W/8.
- MEM_LAT, 1: access cycles spent in ACCESS, legal range 1..15.

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  stage can accept a request.
- icode  in  4  instruction code.
- valE  in  64  ALU result / address.
- valA  in  64  register operand / address.
- valP  in  64  next PC.
- instr_valid  in  1  fetch/decode found a legal instruction.
- imem_error  in  1  fetch address error.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- valM  out  DATA_W  read data; 0 for non-read or errored operations.
- stat  out  2  AOK=00, HLT=01, ADR=10, INS=11.
- dmem_err  out  1  data-memory address error on this operation.

## Operation
- Reads:
  - mrmovq (5) reads at valE.
  - ret (9) and popq (B) read at valA.
- Writes:
  - rmmovq (4) writes valA at valE.
  - pushq (A) writes valA at valE.
  - call (8) writes valP at valE.
- All other icodes make no access.
- Word layout: little-endian; byte addr+i holds data[8i+7:8i].
- Address error:
  - dmem_err = 1 for a memory op if any of valE/valA[63:ADDR_W] is nonzero, or if addr + BYTES − 1 > 2^ADDR_W − 1.
  - The sum is computed at ADDR_W+1 bits, so there is no wrap-around.
- On dmem_err:
  - writes are suppressed;
  - valM = 0.
- stat priority:
  - imem_error → ADR;
  - else !instr_valid → INS;
  - else dmem_err → ADR;
  - else icode 0 (halt) → HLT;
  - else AOK.
- If stat is ADR or INS from fetch (imem_error or !instr_valid), no memory access occurs regardless of icode.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, capture the inputs. A valid, error-free memory op goes to ACCESS; any other op goes to DONE.
  - ACCESS: the counter runs MEM_LAT cycles. On the final edge the write commits, read data is latched into valM, and the FSM moves to DONE.
  - DONE: out_valid = 1; valM, stat and dmem_err are held stable. On out_ready, return to IDLE.
- in_ready = 0 in ACCESS and DONE, so at most one operation is in flight.
- Memory contents are not cleared by reset; only the control state is reset.

## Timing
- Reset values (rst low at an edge):
  - FSM → IDLE, counter → 0;
  - out_valid = 0, valM = 0, stat = 00, dmem_err = 0;
  - in_ready = 0 while rst is low.
- Latency, counted from the accept edge (in_valid & in_ready):
  - memory ops: out_valid rises after MEM_LAT edges;
  - non-memory, errored or fetch-faulted ops: out_valid rises after 1 edge.
- Throughput: one operation per latency + 1 cycles minimum. No overlap or bypass.
- Back-pressure: out_ready low holds DONE indefinitely with the outputs unchanged.
- Reset mid-ACCESS: a pending write is dropped, memory is unchanged, and no result is produced.
- Inputs are sampled only at the accept edge; later changes are ignored.

## Structure
- Package dmem_pkg holds:
  - icode constants (HALT, RMMOVQ, MRMOVQ, CALL, RET, PUSHQ, POPQ);
  - the stat enum (AOK/HLT/ADR/INS);
  - the FSM state enum (IDLE/ACCESS/DONE).
- Sub-module byte_ram (parameters ADDR_W, DATA_W):
  - 2^ADDR_W × 8 array;
  - word read port and word write port with per-byte write enables;
  - synchronous write, no reset.
- Top-level dmem_stage contains the decode, bounds check, FSM, latency counter and output registers.

## Test plan
Configuration for all scenarios: ADDR_W=16, DATA_W=64, MEM_LAT=2.
- Write then read:
  - Stimulus: icode 4, valE=58, valA=12; then icode 5, valE=58.
  - Required: the second result has valM=12, stat=AOK, dmem_err=0.
  - Required: each out_valid rises 2 edges after its accept edge.
- Bounds:
  - Stimulus: icode 4 at valE=65536, then at valE=65529.
  - Required: both give dmem_err=1, stat=ADR, latency 1, no write.
  - Required: icode 4 at valE=65528 gives AOK, and a read-back at valE=65528 matches the written value.
- Call/ret:
  - Stimulus: icode 8, valE=100, valP=11; then icode 9, valA=100.
  - Required: valM=11, stat=AOK.
  - Required: bytes 100..107 read back as 0B 00 … 00.
- Fetch faults:
  - Stimulus: instr_valid=0 → required: stat=INS, latency 1, no access.
  - Stimulus: instr_valid=0 with imem_error=1 → required: stat=ADR.
  - Stimulus: icode 0 → required: stat=HLT, valM=0.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 3 cycles in DONE.
  - Required: outputs stable, in_ready=0; returns to IDLE on the edge where out_ready=1.
- Reset mid-write:
  - Stimulus: rst low during the ACCESS of icode 4, valE=200, valA=99; then icode 5, valE=200.
  - Required: out_valid=0 after the reset edge; the later read returns the prior contents, not 99.
